// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path: frame constants,
// well-known scan-code prefixes, the receiver FSM state type and the
// odd-parity check used to validate a completed frame.
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } ps2_state_t;

  // PS/2 uses odd parity: the eight data bits plus the parity bit must
  // hold an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] code,
                                             input logic       parity);
    return ^{code, parity};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ---------------------------------------------------------------------------
// ps2_fifo
// Generic first-word-fall-through synchronous FIFO. The head entry is
// always visible on o_rd_data while o_empty is low. A write presented while
// full is still accepted when a read is accepted on the same edge, so the
// occupancy stays at DEPTH instead of losing the new word.
//
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset, empties the FIFO
//   i_wr_en    push request
//   i_wr_data  word to push
//   i_rd_en    pop request, ignored while empty
//   o_rd_data  head entry (zero while empty)
//   o_empty    no entries stored
//   o_full     DEPTH entries stored
// ---------------------------------------------------------------------------
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_rd;
  logic             w_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  // Gate the head so a drained FIFO presents zero rather than stale data.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // When full with a simultaneous pop, the write slot is the slot being
  // vacated; the old head has already been presented combinationally.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard frame receiver. Synchronises the raw PS/2 clock and data
// pins, deserialises 11-bit device-to-host frames on falling edges of the
// PS/2 clock, validates start/parity/stop and queues good scan codes in a
// FWFT FIFO for the downstream decoder.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_ps2_clk    raw PS/2 clock pin (asynchronous)
//   i_ps2_data   raw PS/2 data pin (asynchronous)
//   i_rd_en      pop strobe for the scan-code FIFO
//   o_data       scan code at the FIFO head, meaningful while o_valid
//   o_valid      FIFO not empty
//   o_overflow   sticky: a good frame was dropped on a full FIFO
//   o_frame_err  one-cycle pulse when a completed frame is malformed
//   o_busy       a frame is partially received
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_rd_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overflow,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int            TW    = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;

  ps2_state_t    r_state;
  logic [3:0]    r_bitcnt;
  logic          r_start;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tcnt;
  logic          r_frame_err;
  logic          r_overflow;

  logic          w_fe;
  logic          w_sample;
  logic          w_frame_ok;
  logic          w_good;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_drop;

  // Both pins idle high, so the synchronisers reset to 1 to avoid a false
  // falling edge right after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign w_fe     = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_sample = r_dat_sync[SYNC_STAGES-1];

  // After the stop bit, r_shift holds {stop, parity, data[7:0]}.
  assign w_frame_ok = !r_start && r_shift[9] &&
                      ps2_odd_parity_ok(r_shift[7:0], r_shift[8]);
  assign w_good     = (r_state == CHECK) && w_frame_ok;

  // A full FIFO is never empty, so any read strobe frees a slot.
  assign w_pop  = i_rd_en && !w_empty;
  assign w_drop = w_good && w_full && !i_rd_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_start     <= 1'b0;
      r_shift     <= '0;
      r_tcnt      <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (w_pop)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (w_fe) begin
            r_start  <= w_sample;
            r_bitcnt <= 4'd1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_fe) begin
            r_tcnt   <= '0;
            r_shift  <= {w_sample, r_shift[9:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'(PS2_FRAME_BITS - 1)) r_state <= CHECK;
          end else if (r_tcnt == TLAST) begin
            // The keyboard stalled mid-frame; drop it silently.
            r_tcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        CHECK: begin
          r_frame_err <= !w_frame_ok;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_good),
    .i_wr_data (r_shift[7:0]),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_data),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign o_valid     = !w_empty;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Self-checking bench for ps2_kbd_rx. The PS/2 bit period is scaled down to
// 16 system clocks and the stall timeout to 100 clocks so the run stays
// short. A queue-based model tracks FIFO contents, the overflow flag and the
// expected frame_err pulse; a negedge process compares the DUT against it
// every cycle, and directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int HALF  = 8;

  logic       i_clk;
  logic       i_rst;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic       i_rd_en;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overflow;
  logic       o_frame_err;
  logic       o_busy;

  logic [7:0] modelQ[$];
  bit         modelOvf;
  bit         expErr;
  bit         checkEn;
  int         compareCount;
  int         mismatchCount;
  logic [7:0] fill [8];

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (3),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .i_rd_en     (i_rd_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_overflow  (o_overflow),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Model of one clock edge of the receive side: optional pop, then an
  // optional completed frame arriving on the same edge.
  task automatic modelEdge(input logic [7:0] code, input bit good,
                           input bit rd);
    bit wasFull;
    bit doPop;
    wasFull = (modelQ.size() == DEPTH);
    doPop   = rd && (modelQ.size() != 0);
    if (doPop) begin
      void'(modelQ.pop_front());
      modelOvf = 1'b0;
    end
    if (good) begin
      if (!wasFull || doPop) modelQ.push_back(code);
      else modelOvf = 1'b1;
    end
  endtask

  // Drives nBits of a frame for code, starting and ending on a negedge.
  // A completed frame lands 4 clk edges after the stop-bit falling edge
  // (3 synchroniser stages + one CHECK cycle); popAtPush strobes rd_en on
  // exactly that edge.
  task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                               input int nBits, input bit popAtPush,
                               input bit pin);
    logic [10:0] frame;
    bit good;
    good  = !badParity;
    frame = {1'b1, ~(^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      i_ps2_data = frame[i];
      repeat (HALF) @(negedge i_clk);
      i_ps2_clk = 1'b0;
      if (i == PS2_FRAME_BITS - 1) begin
        repeat (3) @(negedge i_clk);
        if (pin) begin
          checkOutput("check_busy", 32'(o_busy), 32'd1);
          checkOutput("latency_valid_lo", 32'(o_valid), 32'd0);
        end
        if (popAtPush) i_rd_en = 1'b1;
        @(posedge i_clk);
        modelEdge(code, good, popAtPush);
        expErr = !good;
        @(negedge i_clk);
        i_rd_en = 1'b0;
        if (pin) begin
          checkOutput("busy_after_check", 32'(o_busy), 32'd0);
          checkOutput("pin_frame_err", 32'(o_frame_err), 32'(badParity));
          checkOutput("pin_valid", 32'(o_valid), 32'(good));
        end
        @(posedge i_clk);
        expErr = 1'b0;
        repeat (HALF - 4) @(negedge i_clk);
      end else begin
        repeat (HALF) @(negedge i_clk);
      end
      i_ps2_clk = 1'b1;
      repeat (HALF) @(negedge i_clk);
    end
    i_ps2_data = 1'b1;
  endtask

  task automatic popOne(input logic [7:0] want);
    checkOutput("pop_valid", 32'(o_valid), 32'd1);
    checkOutput("pop_data", 32'(o_data), 32'(want));
    i_rd_en = 1'b1;
    @(posedge i_clk);
    modelEdge(8'h00, 1'b0, 1'b1);
    @(negedge i_clk);
    i_rd_en = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (checkEn) begin
      checkOutput("valid", 32'(o_valid), 32'(modelQ.size() != 0));
      if (modelQ.size() != 0)
        checkOutput("data", 32'(o_data), 32'(modelQ[0]));
      checkOutput("overflow", 32'(o_overflow), 32'(modelOvf));
      checkOutput("frame_err", 32'(o_frame_err), 32'(expErr));
    end
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    checkEn    = 1'b0;
    expErr     = 1'b0;
    modelOvf   = 1'b0;
    i_rst      = 1'b0;
    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
    i_rd_en    = 1'b0;
    fill = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, PS2_EXT};

    #3 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_overflow", 32'(o_overflow), 32'd0);
    checkOutput("rst_frame_err", 32'(o_frame_err), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    i_rst   = 1'b0;
    checkEn = 1'b1;
    repeat (4) @(negedge i_clk);

    $display("[TB] single good frame 0x1C");
    applyStimulus(8'h1C, 1'b0, 11, 1'b0, 1'b1);
    checkOutput("t1_data", 32'(o_data), 32'h1C);
    popOne(8'h1C);
    checkOutput("t1_empty", 32'(o_valid), 32'd0);
    i_rd_en = 1'b1;
    @(negedge i_clk);
    i_rd_en = 1'b0;
    checkOutput("t1_empty_pop", 32'(o_valid), 32'd0);
    repeat (HALF) @(negedge i_clk);

    $display("[TB] bad parity frame");
    applyStimulus(8'h1C, 1'b1, 11, 1'b0, 1'b1);
    checkOutput("t2_valid", 32'(o_valid), 32'd0);

    $display("[TB] overflow with nine frames");
    for (int k = 1; k <= 9; k++) applyStimulus(8'(k), 1'b0, 11, 1'b0, 1'b0);
    checkOutput("t3_ovf_set", 32'(o_overflow), 32'd1);
    popOne(8'h01);
    checkOutput("t3_ovf_clear", 32'(o_overflow), 32'd0);
    for (int k = 2; k <= 8; k++) popOne(8'(k));
    checkOutput("t3_drained", 32'(o_valid), 32'd0);

    $display("[TB] partial frame timeout");
    applyStimulus(8'hAA, 1'b0, 5, 1'b0, 1'b0);
    checkOutput("t4_busy_partial", 32'(o_busy), 32'd1);
    repeat (TMO + 10) @(negedge i_clk);
    checkOutput("t4_busy_timeout", 32'(o_busy), 32'd0);
    checkOutput("t4_no_push", 32'(o_valid), 32'd0);
    applyStimulus(PS2_BREAK, 1'b0, 11, 1'b0, 1'b0);
    checkOutput("t4_data", 32'(o_data), 32'hF0);
    checkOutput("t4_valid", 32'(o_valid), 32'd1);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(8'h5A, 1'b0, 4, 1'b0, 1'b0);
    #2 i_rst = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
    expErr   = 1'b0;
    #1;
    checkOutput("t5_data", 32'(o_data), 32'd0);
    checkOutput("t5_valid", 32'(o_valid), 32'd0);
    checkOutput("t5_overflow", 32'(o_overflow), 32'd0);
    checkOutput("t5_frame_err", 32'(o_frame_err), 32'd0);
    checkOutput("t5_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    @(negedge i_clk);
    applyStimulus(8'h5A, 1'b0, 11, 1'b0, 1'b0);
    popOne(8'h5A);

    $display("[TB] push and pop on a full FIFO");
    for (int k = 0; k < 8; k++) applyStimulus(fill[k], 1'b0, 11, 1'b0, 1'b0);
    checkOutput("t6_full_no_ovf", 32'(o_overflow), 32'd0);
    applyStimulus(8'h33, 1'b0, 11, 1'b1, 1'b0);
    checkOutput("t6_ovf", 32'(o_overflow), 32'd0);
    for (int k = 1; k < 8; k++) popOne(fill[k]);
    popOne(8'h33);
    checkOutput("t6_drained", 32'(o_valid), 32'd0);

    repeat (4) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
